arb2_mux_ctrl: RTL and testbench
================================

Name: arb2_mux_ctrl

Overview:
Round-robin controller that shares a 2:1 datapath mux between two packet requesters and drives its select line. Owns burst sequencing: grants one requester, forwards its valid/ready handshake to the single downstream consumer, and releases on the last beat, on a burst-length cap, or on an abort. Sits directly in front of a bank of WIDTH 2:1 mux cells; sel=0 selects requester 0, sel=1 selects requester 1.

Parameters:
MAX_BURST, 16, maximum beats per grant before forced release; legal range 1..255.
CW, $clog2(MAX_BURST+1), beat counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants ownership; held high for the whole packet
req1  input  1  requester 1 wants ownership
vld0  input  1  requester 0 beat valid
vld1  input  1  requester 1 beat valid
last0  input  1  requester 0 final beat of packet, qualified by vld0
last1  input  1  requester 1 final beat of packet, qualified by vld1
out_ready  input  1  downstream accepts a beat
gnt0  output  1  requester 0 owns the mux (registered)
gnt1  output  1  requester 1 owns the mux (registered)
rdy0  output  1  beat accept to requester 0 = gnt0 & out_ready
rdy1  output  1  beat accept to requester 1 = gnt1 & out_ready
sel  output  1  mux select (registered)
out_valid  output  1  (gnt0 & vld0) | (gnt1 & vld1)
out_last  output  1  (gnt0 & vld0 & last0) | (gnt1 & vld1 & last1)
beat_cnt  output  CW  beats transferred in the current grant
abort  output  1  one-cycle pulse: owner dropped req mid-packet

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, gnt0=gnt1=0, sel=0, beat_cnt=0, abort=0, last_owner=1 (so requester 0 wins the first tie). rdy*/out_valid/out_last are combinational and therefore 0.
- Transfer: xfer = out_valid & out_ready, evaluated on the rising edge.
- States: IDLE, OWN0, OWN1. gnt0=(state==OWN0), gnt1=(state==OWN1). gnt0 and gnt1 are never high together.
- IDLE: req0 only -> OWN0. req1 only -> OWN1. Both high -> the requester that is not last_owner. Neither -> stay. On entry to OWNi: sel<=i, last_owner<=i, beat_cnt<=0. Grant latency: 1 cycle from req sampled high in IDLE.
- OWNi: each xfer increments beat_cnt. Release to IDLE on the edge where any of the following holds: (a) xfer & last_i; (b) xfer and beat_cnt+1==MAX_BURST (forced release; the remainder of the packet re-arbitrates later); (c) req_i low -> abort<=1 for exactly one cycle, with no transfer counted unless xfer also occurs that edge.
- Priority when several release conditions occur at once: (c) flags abort regardless; (a) and (b) together give a single release.
- Release always spends exactly one cycle in IDLE; the other requester cannot be granted earlier. Back-to-back grants to the same requester are legal only if the other is not requesting.
- sel holds its value through IDLE and changes only on entry to OWNi. The mux data is therefore stable for the whole grant.
- Stall: out_ready low holds state, beat_cnt and grant; the requester must hold data.
- beat_cnt saturates by construction (release at MAX_BURST). It resets to 0 on each new grant and holds its final value in IDLE.
- MAX_BURST=1: every beat releases.
- Reset mid-burst: immediate return to reset values; no abort pulse.

Test Plan:
- Reset release, req0=1 only, 3 beats with last on the 3rd, out_ready=1 -> gnt0 high cycle after req; sel=0; beat_cnt 0,1,2,3; gnt0 drops edge after last; one IDLE cycle.
- req0=req1=1 from reset, 2-beat packets each, both hold req -> grant order 0,1,0,1; sel toggles 0,1,0,1; exactly one IDLE cycle between grants.
- MAX_BURST=4, req1 sends 10-beat packet, req0 idle -> gnt1 for 4 beats, IDLE, 4 beats, IDLE, 2 beats; beat_cnt peaks 4,4,2.
- OWN0, out_ready toggled 1,0,0,1 with vld0=1 -> beat_cnt advances only on ready cycles; gnt0 and sel stable throughout.
- OWN1 after 2 beats, req1 dropped, req0 high -> abort pulses 1 cycle, IDLE next, gnt0 following cycle, sel=0.
- rst_n low mid-OWN1 at beat 5 -> gnt1=0, sel=0, beat_cnt=0 asynchronously, no abort. After release with both requesting, requester 0 is granted first.

Source files
------------

// File: rtl/arb2_mux_ctrl.sv
// Round-robin owner of a shared 2:1 packet mux: grants one requester at a time,
// forwards its valid/ready handshake downstream and releases on last, burst cap or abort.
module arb2_mux_ctrl #(
    parameter int   MAX_BURST = 16,
    localparam int  CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          vld0,
    input  logic          vld1,
    input  logic          last0,
    input  logic          last1,
    input  logic          out_ready,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rdy0,
    output logic          rdy1,
    output logic          sel,
    output logic          out_valid,
    output logic          out_last,
    output logic [CW-1:0] beat_cnt,
    output logic          abort
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [CW-1:0] CAP_M1 = CW'(MAX_BURST - 1);

    state_t state;
    logic   last_owner;
    logic   xfer;
    logic   own_req;
    logic   cap_hit;
    logic   release_now;

    assign rdy0      = gnt0 & out_ready;
    assign rdy1      = gnt1 & out_ready;
    assign out_valid = (gnt0 & vld0) | (gnt1 & vld1);
    assign out_last  = (gnt0 & vld0 & last0) | (gnt1 & vld1 & last1);
    assign xfer      = out_valid & out_ready;

    // out_last is already qualified by the owner's valid, so xfer & out_last is a true last beat.
    assign own_req     = gnt0 ? req0 : req1;
    assign cap_hit     = (beat_cnt == CAP_M1);
    assign release_now = !own_req || (xfer && (out_last || cap_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            sel        <= 1'b0;
            beat_cnt   <= '0;
            abort      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    // On a tie the requester that did not own the mux last time wins.
                    if (req0 && (!req1 || last_owner)) begin
                        state      <= OWN0;
                        gnt0       <= 1'b1;
                        sel        <= 1'b0;
                        last_owner <= 1'b0;
                        beat_cnt   <= '0;
                    end else if (req1) begin
                        state      <= OWN1;
                        gnt1       <= 1'b1;
                        sel        <= 1'b1;
                        last_owner <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                    abort <= !own_req;
                    if (release_now) begin
                        state <= IDLE;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Bench for arb2_mux_ctrl: two instances (burst caps 16 and 4) share one stimulus and
// are each checked every cycle against a transaction-level ownership model.
module tb_arb2_mux_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0, req1, vld0, vld1, last0, last1, out_ready;

    logic       a_gnt0, a_gnt1, a_rdy0, a_rdy1, a_sel, a_out_valid, a_out_last, a_abort;
    logic [4:0] a_beat_cnt;
    logic       b_gnt0, b_gnt1, b_rdy0, b_rdy1, b_sel, b_out_valid, b_out_last, b_abort;
    logic [2:0] b_beat_cnt;

    int n_total = 0;
    int n_bad   = 0;

    int pkt0, pkt1, rl0, rl1;
    bit focus;

    always #5 clk = ~clk;

    arb2_mux_ctrl #(.MAX_BURST(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .vld0(vld0), .vld1(vld1),
        .last0(last0), .last1(last1), .out_ready(out_ready), .gnt0(a_gnt0), .gnt1(a_gnt1),
        .rdy0(a_rdy0), .rdy1(a_rdy1), .sel(a_sel), .out_valid(a_out_valid),
        .out_last(a_out_last), .beat_cnt(a_beat_cnt), .abort(a_abort)
    );

    arb2_mux_ctrl #(.MAX_BURST(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .vld0(vld0), .vld1(vld1),
        .last0(last0), .last1(last1), .out_ready(out_ready), .gnt0(b_gnt0), .gnt1(b_gnt1),
        .rdy0(b_rdy0), .rdy1(b_rdy1), .sel(b_sel), .out_valid(b_out_valid),
        .out_last(b_out_last), .beat_cnt(b_beat_cnt), .abort(b_abort)
    );

    // Model: who owns the mux (-1 = nobody), beats taken in this grant, last winner.
    typedef struct packed {
        int owner;
        int cnt;
        int last_owner;
        bit sel;
        bit abort;
    } mstate_t;

    localparam mstate_t MRST = '{owner: -1, cnt: 0, last_owner: 1, sel: 1'b0, abort: 1'b0};

    mstate_t ma = MRST;
    mstate_t mb = MRST;

    function automatic mstate_t mnext(input mstate_t s, input int cap);
        mstate_t n;
        int      pick;
        bit      holding, v, lst, moved;
        n       = s;
        n.abort = 1'b0;
        pick    = -1;
        if (s.owner < 0) begin
            if (req0 && req1)  pick = 1 - s.last_owner;
            else if (req0)     pick = 0;
            else if (req1)     pick = 1;
            if (pick >= 0) begin
                n.owner      = pick;
                n.last_owner = pick;
                n.sel        = (pick == 1);
                n.cnt        = 0;
            end
        end else begin
            holding = (s.owner == 0) ? req0 : req1;
            v       = (s.owner == 0) ? vld0 : vld1;
            lst     = (s.owner == 0) ? last0 : last1;
            moved   = v && out_ready;
            if (moved) n.cnt = s.cnt + 1;
            n.abort = !holding;
            if (!holding || (moved && (lst || n.cnt == cap))) n.owner = -1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= MRST;
            mb <= MRST;
        end else begin
            ma <= mnext(ma, 16);
            mb <= mnext(mb, 4);
        end
    end

    function automatic logic [15:0] expv(input mstate_t s);
        logic g0, g1;
        g0 = (s.owner == 0);
        g1 = (s.owner == 1);
        return {g0, g1, g0 & out_ready, g1 & out_ready, s.sel, (g0 & vld0) | (g1 & vld1),
                (g0 & vld0 & last0) | (g1 & vld1 & last1), s.abort, 8'(s.cnt)};
    endfunction

    initial begin
        logic [15:0] got, exp;
        forever begin
            @(negedge clk);
            got = {a_gnt0, a_gnt1, a_rdy0, a_rdy1, a_sel, a_out_valid, a_out_last, a_abort,
                   8'(a_beat_cnt)};
            exp = expv(ma);
            n_total++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL cycle_a t=%0t: got %h expected %h", $time, got, exp);
            end
            got = {b_gnt0, b_gnt1, b_rdy0, b_rdy1, b_sel, b_out_valid, b_out_last, b_abort,
                   8'(b_beat_cnt)};
            exp = expv(mb);
            n_total++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL cycle_b t=%0t: got %h expected %h", $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic apply();
        req0  = (pkt0 > 0);
        vld0  = req0;
        last0 = (pkt0 == 1);
        req1  = (pkt1 > 0);
        vld1  = req1;
        last1 = (pkt1 == 1);
    endtask

    // Requesters advance on the beats accepted by the focused instance.
    task automatic step(input int n);
        bit x0, x1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            x0 = vld0 && (focus ? b_rdy0 : a_rdy0);
            x1 = vld1 && (focus ? b_rdy1 : a_rdy1);
            @(posedge clk);
            #2;
            if (x0) begin
                pkt0--;
                if (pkt0 == 0) pkt0 = rl0;
            end
            if (x1) begin
                pkt1--;
                if (pkt1 == 0) pkt1 = rl1;
            end
            apply();
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pkt0      = 0;
        pkt1      = 0;
        rl0       = 0;
        rl1       = 0;
        out_ready = 1'b1;
        apply();
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        focus = 1'b0;
        do_reset();
        rst_n = 1'b0;
        step(1);
        chk("rst_gnt0", a_gnt0, 0);
        chk("rst_sel", a_sel, 0);
        chk("rst_cnt", a_beat_cnt, 0);
        rst_n = 1'b1;

        // Single requester, 3-beat packet.
        pkt0 = 3;
        apply();
        step(1);
        chk("t1_gnt0", a_gnt0, 1);
        chk("t1_cnt0", a_beat_cnt, 0);
        step(1);
        chk("t1_cnt1", a_beat_cnt, 1);
        step(2);
        chk("t1_rel_gnt0", a_gnt0, 0);
        chk("t1_rel_cnt", a_beat_cnt, 3);

        // Both requesting continuously: alternating grants with one idle cycle between.
        do_reset();
        pkt0 = 2; pkt1 = 2; rl0 = 2; rl1 = 2;
        apply();
        step(1);
        chk("t2_g0_first", a_gnt0, 1);
        chk("t2_sel0", a_sel, 0);
        step(2);
        chk("t2_idle_gnts", {a_gnt0, a_gnt1}, 0);
        step(1);
        chk("t2_g1", a_gnt1, 1);
        chk("t2_sel1", a_sel, 1);
        step(2);
        chk("t2_idle_sel_hold", {a_gnt0, a_gnt1, a_sel}, 1);
        step(1);
        chk("t2_g0_again", a_gnt0, 1);
        chk("t2_sel0_again", a_sel, 0);
        step(3);
        chk("t2_g1_again", a_gnt1, 1);

        // Burst cap of 4 on a 10-beat packet.
        focus = 1'b1;
        do_reset();
        pkt1 = 10;
        apply();
        step(1);
        chk("t3_g1", b_gnt1, 1);
        step(4);
        chk("t3_cap1_cnt", b_beat_cnt, 4);
        chk("t3_cap1_gnt", b_gnt1, 0);
        step(1);
        chk("t3_regrant", b_gnt1, 1);
        chk("t3_regrant_cnt", b_beat_cnt, 0);
        step(4);
        chk("t3_cap2_cnt", b_beat_cnt, 4);
        step(1);
        step(2);
        chk("t3_tail_cnt", b_beat_cnt, 2);
        chk("t3_tail_gnt", b_gnt1, 0);

        // Downstream stalls.
        focus = 1'b0;
        do_reset();
        pkt0 = 8;
        apply();
        step(1);
        out_ready = 1'b1;
        step(1);
        chk("t4_cnt_a", a_beat_cnt, 1);
        out_ready = 1'b0;
        step(1);
        chk("t4_stall_gnt", a_gnt0, 1);
        out_ready = 1'b0;
        step(1);
        chk("t4_stall_cnt", a_beat_cnt, 1);
        out_ready = 1'b1;
        step(1);
        chk("t4_cnt_b", a_beat_cnt, 2);
        chk("t4_sel", a_sel, 0);

        // Owner drops its request mid-packet.
        do_reset();
        pkt1 = 6;
        apply();
        step(1);
        chk("t5_g1", a_gnt1, 1);
        step(2);
        chk("t5_cnt", a_beat_cnt, 2);
        pkt1 = 0;
        pkt0 = 3;
        apply();
        step(1);
        chk("t5_abort", a_abort, 1);
        chk("t5_idle", {a_gnt0, a_gnt1}, 0);
        step(1);
        chk("t5_g0", a_gnt0, 1);
        chk("t5_sel", a_sel, 0);
        chk("t5_abort_end", a_abort, 0);
        step(3);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        pkt1 = 10;
        apply();
        step(1);
        step(5);
        chk("t6_cnt5", a_beat_cnt, 5);
        pkt0 = 4;
        apply();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt1", a_gnt1, 0);
        chk("t6_rst_sel", a_sel, 0);
        chk("t6_rst_cnt", a_beat_cnt, 0);
        chk("t6_rst_abort", a_abort, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("t6_g0_first", a_gnt0, 1);
        chk("t6_g1_low", a_gnt1, 0);
        step(14);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
